// File: rtl/exu_issue_ctrl_if.sv
// exu_issue_ctrl_if: decode, MEM/WB forwarding and EXU signal bundle for the issue controller
interface exu_issue_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32
);
  logic                  flush_i;
  logic                  id_valid_i;
  logic                  id_ready_o;
  logic [DATA_WIDTH-1:0] id_pc_i;
  logic [DATA_WIDTH-1:0] id_imme_i;
  logic [DATA_WIDTH-1:0] id_rs1_data_i;
  logic [DATA_WIDTH-1:0] id_rs2_data_i;
  logic [REG_AW-1:0]     id_rs1_addr_i;
  logic [REG_AW-1:0]     id_rs2_addr_i;
  logic [REG_AW-1:0]     id_rd_addr_i;
  logic                  id_ers1_i;
  logic                  id_ers2_i;
  logic [2:0]            id_specinst_i;
  logic                  id_is_load_i;
  logic                  mem_valid_i;
  logic                  mem_is_load_i;
  logic [REG_AW-1:0]     mem_rd_addr_i;
  logic [DATA_WIDTH-1:0] mem_rd_data_i;
  logic                  wb_valid_i;
  logic [REG_AW-1:0]     wb_rd_addr_i;
  logic [DATA_WIDTH-1:0] wb_rd_data_i;
  logic                  ex_valid_o;
  logic                  ex_ready_i;
  logic                  ex_ers1_o;
  logic                  ex_ers2_o;
  logic [2:0]            ex_specinst_o;
  logic                  ex_is_load_o;
  logic [DATA_WIDTH-1:0] ex_pc_o;
  logic [DATA_WIDTH-1:0] ex_imme_o;
  logic [DATA_WIDTH-1:0] ex_rs1_o;
  logic [DATA_WIDTH-1:0] ex_rs2_o;
  logic [REG_AW-1:0]     ex_rd_addr_o;
  logic [CNT_W-1:0]      stall_cnt_o;
  logic [CNT_W-1:0]      issue_cnt_o;

  modport slave (
    input  flush_i, id_valid_i, id_pc_i, id_imme_i, id_rs1_data_i, id_rs2_data_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_ers1_i, id_ers2_i,
           id_specinst_i, id_is_load_i, mem_valid_i, mem_is_load_i, mem_rd_addr_i,
           mem_rd_data_i, wb_valid_i, wb_rd_addr_i, wb_rd_data_i, ex_ready_i,
    output id_ready_o, ex_valid_o, ex_ers1_o, ex_ers2_o, ex_specinst_o, ex_is_load_o,
           ex_pc_o, ex_imme_o, ex_rs1_o, ex_rs2_o, ex_rd_addr_o, stall_cnt_o, issue_cnt_o
  );

  modport master (
    output flush_i, id_valid_i, id_pc_i, id_imme_i, id_rs1_data_i, id_rs2_data_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_ers1_i, id_ers2_i,
           id_specinst_i, id_is_load_i, mem_valid_i, mem_is_load_i, mem_rd_addr_i,
           mem_rd_data_i, wb_valid_i, wb_rd_addr_i, wb_rd_data_i, ex_ready_i,
    input  id_ready_o, ex_valid_o, ex_ers1_o, ex_ers2_o, ex_specinst_o, ex_is_load_o,
           ex_pc_o, ex_imme_o, ex_rs1_o, ex_rs2_o, ex_rd_addr_o, stall_cnt_o, issue_cnt_o
  );
endinterface

// File: rtl/exu_issue_ctrl.sv
// exu_issue_ctrl: one-slot decode-to-EXU issue stage with MEM/WB forwarding and load-use stall
module exu_issue_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  exu_issue_ctrl_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc, r_imme, r_rs1, r_rs2;
  logic [REG_AW-1:0]     r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic                  r_ers1, r_ers2, r_is_load;
  logic [2:0]            r_specinst;
  logic [CNT_W-1:0]      r_stall_cnt, r_issue_cnt;
  logic                  w_full, w_hazard, w_issue, w_accept, w_mem_alu;
  logic [DATA_WIDTH-1:0] w_rs1_cap, w_rs2_cap, w_rs1_wb, w_rs2_wb;

  function automatic logic hit(input logic used, input logic [REG_AW-1:0] src,
                               input logic [REG_AW-1:0] dst);
    return used && src != '0 && src == dst;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic used, input logic [REG_AW-1:0] src, input logic [DATA_WIDTH-1:0] stored,
    input logic mem_ok, input logic [REG_AW-1:0] mem_a, input logic [DATA_WIDTH-1:0] mem_d,
    input logic wb_ok, input logic [REG_AW-1:0] wb_a, input logic [DATA_WIDTH-1:0] wb_d);
    return (mem_ok && hit(used, src, mem_a)) ? mem_d :
           (wb_ok && hit(used, src, wb_a))   ? wb_d  : stored;
  endfunction

  assign w_full    = r_state == FULL;
  assign w_mem_alu = bus.mem_valid_i && !bus.mem_is_load_i;
  assign w_hazard  = w_full && bus.mem_valid_i && bus.mem_is_load_i &&
                     (hit(r_ers1, r_rs1_addr, bus.mem_rd_addr_i) ||
                      hit(r_ers2, r_rs2_addr, bus.mem_rd_addr_i));
  assign w_issue   = bus.ex_valid_o && bus.ex_ready_i;
  assign w_accept  = bus.id_valid_i && bus.id_ready_o;

  assign w_rs1_cap = fwd(bus.id_ers1_i, bus.id_rs1_addr_i, bus.id_rs1_data_i, w_mem_alu,
                         bus.mem_rd_addr_i, bus.mem_rd_data_i, bus.wb_valid_i,
                         bus.wb_rd_addr_i, bus.wb_rd_data_i);
  assign w_rs2_cap = fwd(bus.id_ers2_i, bus.id_rs2_addr_i, bus.id_rs2_data_i, w_mem_alu,
                         bus.mem_rd_addr_i, bus.mem_rd_data_i, bus.wb_valid_i,
                         bus.wb_rd_addr_i, bus.wb_rd_data_i);
  assign w_rs1_wb  = fwd(r_ers1, r_rs1_addr, r_rs1, 1'b0, bus.mem_rd_addr_i, bus.mem_rd_data_i,
                         bus.wb_valid_i, bus.wb_rd_addr_i, bus.wb_rd_data_i);
  assign w_rs2_wb  = fwd(r_ers2, r_rs2_addr, r_rs2, 1'b0, bus.mem_rd_addr_i, bus.mem_rd_data_i,
                         bus.wb_valid_i, bus.wb_rd_addr_i, bus.wb_rd_data_i);

  assign bus.id_ready_o    = !bus.flush_i && (!w_full || w_issue);
  assign bus.ex_valid_o    = w_full && !w_hazard && !bus.flush_i;
  assign bus.ex_rs1_o      = fwd(r_ers1, r_rs1_addr, r_rs1, w_mem_alu, bus.mem_rd_addr_i,
                                 bus.mem_rd_data_i, bus.wb_valid_i, bus.wb_rd_addr_i,
                                 bus.wb_rd_data_i);
  assign bus.ex_rs2_o      = fwd(r_ers2, r_rs2_addr, r_rs2, w_mem_alu, bus.mem_rd_addr_i,
                                 bus.mem_rd_data_i, bus.wb_valid_i, bus.wb_rd_addr_i,
                                 bus.wb_rd_data_i);
  assign bus.ex_ers1_o     = r_ers1;
  assign bus.ex_ers2_o     = r_ers2;
  assign bus.ex_specinst_o = r_specinst;
  assign bus.ex_is_load_o  = r_is_load;
  assign bus.ex_pc_o       = r_pc;
  assign bus.ex_imme_o     = r_imme;
  assign bus.ex_rd_addr_o  = r_rd_addr;
  assign bus.stall_cnt_o   = r_stall_cnt;
  assign bus.issue_cnt_o   = r_issue_cnt;

  // slot occupancy: flush drops, accept fills (even while issuing), a lone issue drains
  always_comb begin
    w_state_nxt = bus.flush_i ? EMPTY : w_accept ? FULL : w_issue ? EMPTY : r_state;
  end

  // occupancy register
  always_ff @(posedge clk_i) begin
    r_state <= rst_i ? EMPTY : w_state_nxt;
  end

  // slot payload: capture forwarded operands on accept, otherwise keep WB results seen while waiting
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {r_pc, r_imme, r_rs1, r_rs2} <= '0;
      {r_rs1_addr, r_rs2_addr, r_rd_addr} <= '0;
      {r_ers1, r_ers2, r_is_load, r_specinst} <= '0;
    end else if (w_accept) begin
      r_pc       <= bus.id_pc_i;
      r_imme     <= bus.id_imme_i;
      r_rs1      <= w_rs1_cap;
      r_rs2      <= w_rs2_cap;
      r_rs1_addr <= bus.id_rs1_addr_i;
      r_rs2_addr <= bus.id_rs2_addr_i;
      r_rd_addr  <= bus.id_rd_addr_i;
      r_ers1     <= bus.id_ers1_i;
      r_ers2     <= bus.id_ers2_i;
      r_is_load  <= bus.id_is_load_i;
      r_specinst <= bus.id_specinst_i;
    end else if (w_full) begin
      r_rs1 <= w_rs1_wb;
      r_rs2 <= w_rs2_wb;
    end
  end

  // performance counters; a flushed cycle counts neither a stall nor an issue
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_issue_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(w_hazard && !bus.flush_i);
      r_issue_cnt <= r_issue_cnt + CNT_W'(w_issue);
    end
  end
endmodule

// File: tb/tb_exu_issue_ctrl.sv
// tb_exu_issue_ctrl: directed stimulus checked every cycle against a slot-level reference model
module tb_exu_issue_ctrl;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  exu_issue_ctrl_if #(.DATA_WIDTH(64), .REG_AW(5), .CNT_W(32)) bus ();
  exu_issue_ctrl #(.DATA_WIDTH(64), .REG_AW(5), .CNT_W(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic [63:0] pc, imme, v1, v2;
    logic [4:0]  a1, a2, rd;
    logic        e1, e2, ld;
    logic [2:0]  sp;
  } slot_t;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] val;
  } lit_t;

  localparam int S_VALID = 0, S_READY = 1, S_RS1 = 2, S_RS2 = 3, S_IMME = 4, S_PC = 5,
                 S_ISSUE = 6, S_STALL = 7;

  int total = 0;
  int bad = 0;
  lit_t lits[$];

  slot_t       m_slot;
  logic        m_full = 0, m_clean = 0, m_known = 0;
  logic [31:0] m_stall = 0, m_issue = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sel_out(input int s);
    case (s)
      S_VALID: return 64'(bus.ex_valid_o);
      S_READY: return 64'(bus.id_ready_o);
      S_RS1:   return bus.ex_rs1_o;
      S_RS2:   return bus.ex_rs2_o;
      S_IMME:  return bus.ex_imme_o;
      S_PC:    return bus.ex_pc_o;
      S_ISSUE: return 64'(bus.issue_cnt_o);
      default: return 64'(bus.stall_cnt_o);
    endcase
  endfunction

  // youngest non-load producer wins, then WB, else the value already held
  function automatic logic [63:0] src_val(input logic used, input logic [4:0] a, input logic [63:0] held);
    if (!used || a == 0) return held;
    if (bus.mem_valid_i && !bus.mem_is_load_i && bus.mem_rd_addr_i == a) return bus.mem_rd_data_i;
    if (bus.wb_valid_i && bus.wb_rd_addr_i == a) return bus.wb_rd_data_i;
    return held;
  endfunction

  function automatic logic waits_on_load(input logic used, input logic [4:0] a);
    return used && a != 0 && bus.mem_valid_i && bus.mem_is_load_i && bus.mem_rd_addr_i == a;
  endfunction

  // compare against the model, then advance the model across the coming edge
  always @(negedge clk) begin
    logic hz, ev, er, iss, acc;
    lit_t l;
    hz  = m_full && (waits_on_load(m_slot.e1, m_slot.a1) || waits_on_load(m_slot.e2, m_slot.a2));
    ev  = m_full && !hz && !bus.flush_i;
    er  = !bus.flush_i && (!m_full || (ev && bus.ex_ready_i));
    iss = ev && bus.ex_ready_i;
    acc = bus.id_valid_i && er;
    if (m_known) begin
      chk("ex_valid", 64'(bus.ex_valid_o), 64'(ev));
      chk("id_ready", 64'(bus.id_ready_o), 64'(er));
      chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_stall));
      chk("issue_cnt", 64'(bus.issue_cnt_o), 64'(m_issue));
      if (m_full || m_clean) begin
        chk("ex_rs1", bus.ex_rs1_o, src_val(m_slot.e1, m_slot.a1, m_slot.v1));
        chk("ex_rs2", bus.ex_rs2_o, src_val(m_slot.e2, m_slot.a2, m_slot.v2));
        chk("ex_pc", bus.ex_pc_o, m_slot.pc);
        chk("ex_imme", bus.ex_imme_o, m_slot.imme);
        chk("ex_rd", 64'(bus.ex_rd_addr_o), 64'(m_slot.rd));
        chk("ex_ctl", 64'({bus.ex_ers1_o, bus.ex_ers2_o, bus.ex_is_load_o, bus.ex_specinst_o}),
            64'({m_slot.e1, m_slot.e2, m_slot.ld, m_slot.sp}));
      end
      while (lits.size() > 0) begin
        l = lits.pop_front();
        chk(l.name, sel_out(l.sel), l.val);
      end
    end
    if (rst) begin
      m_slot  = '{default: '0};
      m_full  = 0;
      m_clean = 1;
      m_known = 1;
      m_stall = 0;
      m_issue = 0;
    end else begin
      if (hz && !bus.flush_i) m_stall++;
      if (iss) m_issue++;
      if (bus.flush_i) m_full = 0;
      else if (acc) begin
        m_slot.pc   = bus.id_pc_i;
        m_slot.imme = bus.id_imme_i;
        m_slot.a1   = bus.id_rs1_addr_i;
        m_slot.a2   = bus.id_rs2_addr_i;
        m_slot.rd   = bus.id_rd_addr_i;
        m_slot.e1   = bus.id_ers1_i;
        m_slot.e2   = bus.id_ers2_i;
        m_slot.ld   = bus.id_is_load_i;
        m_slot.sp   = bus.id_specinst_i;
        m_slot.v1   = src_val(bus.id_ers1_i, bus.id_rs1_addr_i, bus.id_rs1_data_i);
        m_slot.v2   = src_val(bus.id_ers2_i, bus.id_rs2_addr_i, bus.id_rs2_data_i);
        m_full  = 1;
        m_clean = 0;
      end else if (iss) m_full = 0;
      else if (m_full) begin
        if (m_slot.e1 && m_slot.a1 != 0 && bus.wb_valid_i && bus.wb_rd_addr_i == m_slot.a1)
          m_slot.v1 = bus.wb_rd_data_i;
        if (m_slot.e2 && m_slot.a2 != 0 && bus.wb_valid_i && bus.wb_rd_addr_i == m_slot.a2)
          m_slot.v2 = bus.wb_rd_data_i;
      end
    end
  end

  task automatic lit(input string n, input int s, input logic [63:0] v);
    lits.push_back('{name: n, sel: s, val: v});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_i = 0; bus.id_valid_i = 0; bus.id_pc_i = 0; bus.id_imme_i = 0;
    bus.id_rs1_data_i = 0; bus.id_rs2_data_i = 0; bus.id_rs1_addr_i = 0; bus.id_rs2_addr_i = 0;
    bus.id_rd_addr_i = 0; bus.id_ers1_i = 0; bus.id_ers2_i = 0; bus.id_specinst_i = 0;
    bus.id_is_load_i = 0; bus.mem_valid_i = 0; bus.mem_is_load_i = 0; bus.mem_rd_addr_i = 0;
    bus.mem_rd_data_i = 0; bus.wb_valid_i = 0; bus.wb_rd_addr_i = 0; bus.wb_rd_data_i = 0;
    bus.ex_ready_i = 0;
  endtask

  task automatic put_id(input logic [63:0] pc, input logic [63:0] imme,
                        input logic [4:0] a1, input logic [63:0] d1, input logic e1,
                        input logic [4:0] a2, input logic [63:0] d2, input logic e2,
                        input logic [4:0] rd, input logic [2:0] sp, input logic ld);
    bus.id_valid_i = 1; bus.id_pc_i = pc; bus.id_imme_i = imme;
    bus.id_rs1_addr_i = a1; bus.id_rs1_data_i = d1; bus.id_ers1_i = e1;
    bus.id_rs2_addr_i = a2; bus.id_rs2_data_i = d2; bus.id_ers2_i = e2;
    bus.id_rd_addr_i = rd; bus.id_specinst_i = sp; bus.id_is_load_i = ld;
  endtask

  task automatic mem(input logic ld, input logic [4:0] a, input logic [63:0] d);
    bus.mem_valid_i = 1; bus.mem_is_load_i = ld; bus.mem_rd_addr_i = a; bus.mem_rd_data_i = d;
  endtask

  task automatic wb(input logic [4:0] a, input logic [63:0] d);
    bus.wb_valid_i = 1; bus.wb_rd_addr_i = a; bus.wb_rd_data_i = d;
  endtask

  initial begin
    idle();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    idle();
    lit("rst_valid", S_VALID, 0); lit("rst_ready", S_READY, 1); lit("rst_issue", S_ISSUE, 0);
    lit("rst_stall", S_STALL, 0); lit("rst_rs1", S_RS1, 0); lit("rst_pc", S_PC, 0);
    cyc();
    put_id(64'h1000, 5, 5'd1, 7, 1, 5'd0, 0, 0, 5'd2, 3'd0, 0);
    lit("addi_ready", S_READY, 1);
    cyc();
    idle(); bus.ex_ready_i = 1;
    lit("addi_valid", S_VALID, 1); lit("addi_rs1", S_RS1, 7); lit("addi_imme", S_IMME, 5);
    lit("addi_pc", S_PC, 64'h1000); lit("addi_issue_pre", S_ISSUE, 0);
    cyc();
    idle();
    lit("addi_issue", S_ISSUE, 1); lit("addi_drained", S_VALID, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      idle();
      put_id(64'h2000 + 64'(4 * i), 64'(i), 5'd0, 0, 0, 5'd0, 0, 0, 5'(10 + i), 3'(i), 0);
      bus.ex_ready_i = 1;
      lit("b2b_ready", S_READY, 1);
      if (i > 0) lit("b2b_valid", S_VALID, 1);
      cyc();
    end
    idle(); bus.ex_ready_i = 1;
    lit("b2b_last_valid", S_VALID, 1); lit("b2b_last_pc", S_PC, 64'h200c);
    cyc();
    idle();
    lit("b2b_issue", S_ISSUE, 5); lit("b2b_empty", S_VALID, 0);
    cyc();
    put_id(64'h3000, 0, 5'd5, 0, 1, 5'd0, 0, 0, 5'd6, 3'd0, 0);
    cyc();
    idle(); bus.ex_ready_i = 1; mem(1, 5'd5, 64'hBAD);
    lit("lu_stall_valid", S_VALID, 0); lit("lu_stall_cnt0", S_STALL, 0);
    cyc();
    idle(); bus.ex_ready_i = 1; wb(5'd5, 64'hDEAD);
    lit("lu_valid", S_VALID, 1); lit("lu_rs1", S_RS1, 64'hDEAD); lit("lu_stall_cnt", S_STALL, 1);
    cyc();
    idle();
    lit("lu_issue", S_ISSUE, 6); lit("lu_stall_hold", S_STALL, 1);
    cyc();
    put_id(64'h3100, 0, 5'd0, 0, 1, 5'd3, 5, 1, 5'd7, 3'd5, 0);
    cyc();
    idle(); mem(0, 5'd3, 64'h11); wb(5'd3, 64'h22);
    lit("prio_rs2_mem", S_RS2, 64'h11); lit("prio_rs1_x0", S_RS1, 0);
    cyc();
    idle(); mem(0, 5'd0, 64'h99); wb(5'd0, 64'h99);
    lit("x0_rs1", S_RS1, 0); lit("wb_kept_rs2", S_RS2, 64'h22);
    cyc();
    idle(); bus.ex_ready_i = 1;
    lit("prio_valid", S_VALID, 1); lit("prio_rs2_held", S_RS2, 64'h22);
    cyc();
    idle();
    lit("prio_issue", S_ISSUE, 7);
    cyc();
    put_id(64'h3200, 0, 5'd4, 1, 1, 5'd0, 0, 0, 5'd8, 3'd0, 0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      idle();
      put_id(64'h4000, 9, 5'd0, 0, 0, 5'd0, 0, 0, 5'd9, 3'd4, 1);
      if (k == 0) wb(5'd4, 64'h44);
      lit("bp_ready", S_READY, 0); lit("bp_valid", S_VALID, 1);
      lit("bp_rs1", S_RS1, 64'h44); lit("bp_pc", S_PC, 64'h3200);
      cyc();
    end
    idle();
    put_id(64'h4000, 9, 5'd0, 0, 0, 5'd0, 0, 0, 5'd9, 3'd4, 1);
    bus.ex_ready_i = 1;
    lit("bp_release_ready", S_READY, 1); lit("bp_release_rs1", S_RS1, 64'h44);
    cyc();
    idle();
    lit("bp_next_pc", S_PC, 64'h4000); lit("bp_issue", S_ISSUE, 8); lit("bp_next_valid", S_VALID, 1);
    cyc();
    idle();
    put_id(64'h5000, 1, 5'd0, 0, 0, 5'd0, 0, 0, 5'd1, 3'd1, 0);
    bus.ex_ready_i = 1; bus.flush_i = 1;
    lit("flush_valid", S_VALID, 0); lit("flush_ready", S_READY, 0);
    cyc();
    idle(); bus.ex_ready_i = 1;
    lit("post_flush_valid", S_VALID, 0); lit("post_flush_ready", S_READY, 1);
    lit("post_flush_issue", S_ISSUE, 8);
    cyc();
    put_id(64'h6000, 0, 5'd6, 0, 1, 5'd0, 0, 0, 5'd2, 3'd2, 0);
    cyc();
    idle(); bus.ex_ready_i = 1; mem(1, 5'd6, 64'h1);
    lit("rst_mid_valid", S_VALID, 0); lit("rst_mid_stall", S_STALL, 1);
    cyc();
    idle(); bus.ex_ready_i = 1; mem(1, 5'd6, 64'h1);
    rst = 1;
    lit("rst_mid_stall2", S_STALL, 2);
    cyc();
    rst = 0;
    idle();
    lit("rst2_valid", S_VALID, 0); lit("rst2_ready", S_READY, 1); lit("rst2_stall", S_STALL, 0);
    lit("rst2_issue", S_ISSUE, 0); lit("rst2_rs1", S_RS1, 0); lit("rst2_pc", S_PC, 0);
    cyc();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
